// File: rtl/burst_ram_arbiter_pkg.sv
// Shared types and constants for the two-requester burst RAM arbiter.
// Used by burst_ram_arbiter and burst_ram_arb_select.
package burst_ram_arbiter_pkg;

  localparam int REQ_COUNT = 2;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_WAIT_CALIB   = 3'd0,
    ST_IDLE         = 3'd1,
    ST_ISSUE        = 3'd2,
    ST_WRITE_BURST  = 3'd3,
    ST_READ_COLLECT = 3'd4,
    ST_WAIT_RAM     = 3'd5,
    ST_DONE         = 3'd6
  } state_e;

endpackage

// File: rtl/burst_ram_arb_select.sv
// Combinational 2-way requester picker: round-robin on ties by default,
// or requester 0 always wins a tie when BURST_ARB_FIXED_PRIORITY_EN is defined.
module burst_ram_arb_select
  import burst_ram_arbiter_pkg::*;
(
  input  logic [REQ_COUNT-1:0] req_en,
  input  logic                 last_grant,
  output logic                 grant_valid,
  output logic                 grant_idx
);

`ifdef BURST_ARB_FIXED_PRIORITY_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant_valid = |req_en;
    grant_idx   = ~req_en[0];
  end
`else
  always_comb begin
    grant_valid = |req_en;
    grant_idx   = req_en[1];
    if (req_en == 2'b11) begin
      grant_idx = ~last_grant;
    end
  end
`endif

endmodule

// File: rtl/burst_ram_arbiter.sv
// Shares one burst RAM port between two line requesters, sequencing each grant as a full burst.
// Tie-break policy comes from burst_ram_arb_select (BURST_ARB_FIXED_PRIORITY_EN selects fixed priority).
//
//  state           | meaning
//  ST_WAIT_CALIB   | wait for RAM calibration done and not busy
//  ST_IDLE         | pick a requester while RAM is not busy
//  ST_ISSUE        | one-cycle command strobe, write word 0
//  ST_WRITE_BURST  | stream write words 1..BDC-1
//  ST_READ_COLLECT | capture BDC valid read words
//  ST_WAIT_RAM     | wait for RAM busy to drop
//  ST_DONE         | one-cycle req_done to the granted requester
module burst_ram_arbiter
  import burst_ram_arbiter_pkg::*;
#(
  parameter int AddressBitWidth = 4,
  parameter int DataBitWidth    = 64,
  parameter int BurstDataCount  = 4
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic [REQ_COUNT-1:0]                             req_en,
  input  logic [REQ_COUNT-1:0]                             req_cmd,
  input  logic [REQ_COUNT*AddressBitWidth-1:0]             req_addr,
  input  logic [REQ_COUNT*DataBitWidth*BurstDataCount-1:0] req_wr_line,
  output logic [REQ_COUNT-1:0]                             req_done,
  output logic [DataBitWidth*BurstDataCount-1:0]           rd_line,
  output logic                                             ram_cmd,
  output logic                                             ram_cmd_en,
  output logic [AddressBitWidth-1:0]                       ram_addr,
  output logic [DataBitWidth-1:0]                          ram_wr_data,
  output logic [DataBitWidth/8-1:0]                        ram_data_mask,
  input  logic [DataBitWidth-1:0]                          ram_rd_data,
  input  logic                                             ram_rd_data_valid,
  input  logic                                             ram_init_calib,
  input  logic                                             ram_busy
);

  localparam int AW    = AddressBitWidth;
  localparam int DW    = DataBitWidth;
  localparam int BDC   = BurstDataCount;
  localparam int LW    = DW * BDC;
  localparam int OFF_W = $clog2(BDC);
  localparam int CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BDC - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BDC);

  state_e                     state, state_nxt;
  logic                       last_grant;
  logic                       gnt_idx;
  logic                       lat_cmd;
  logic [AW-1:0]              lat_addr;
  logic [BDC-1:0][DW-1:0]     lat_words;
  logic [BDC-1:0][DW-1:0]     rd_q;
  logic [CNT_W-1:0]           cnt;

  logic                       grant_valid;
  logic                       grant_sel;
  logic                       grant_fire;
  logic                       rd_fire;
  logic                       sel_cmd;
  logic [AW-1:0]              sel_addr;
  logic [LW-1:0]              sel_line;

  burst_ram_arb_select u_select (
    .req_en      (req_en),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_sel)
  );

  assign sel_cmd    = req_cmd[grant_sel];
  assign sel_addr   = grant_sel ? req_addr[AW +: AW] : req_addr[0 +: AW];
  assign sel_line   = grant_sel ? req_wr_line[LW +: LW] : req_wr_line[0 +: LW];
  assign grant_fire = (state == ST_IDLE) && grant_valid && !ram_busy;
  assign rd_fire    = (state == ST_READ_COLLECT) && ram_rd_data_valid && (cnt < CNT_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_WAIT_CALIB;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT_CALIB:   if (ram_init_calib && !ram_busy) state_nxt = ST_IDLE;
      ST_IDLE:         if (grant_valid && !ram_busy) state_nxt = ST_ISSUE;
      ST_ISSUE:        state_nxt = (lat_cmd == CMD_WRITE) ? ST_WRITE_BURST : ST_READ_COLLECT;
      ST_WRITE_BURST:  if (cnt == CNT_LAST) state_nxt = ST_WAIT_RAM;
      ST_READ_COLLECT: if (rd_fire && (cnt == CNT_LAST)) state_nxt = ST_WAIT_RAM;
      ST_WAIT_RAM:     if (!ram_busy) state_nxt = ST_DONE;
      ST_DONE:         state_nxt = ST_IDLE;
      default:         state_nxt = ST_WAIT_CALIB;
    endcase
  end

  always_comb begin
    req_done    = '0;
    ram_cmd_en  = 1'b0;
    ram_cmd     = CMD_READ;
    ram_addr    = '0;
    ram_wr_data = '0;
    case (state)
      ST_ISSUE: begin
        ram_cmd_en  = 1'b1;
        ram_cmd     = lat_cmd;
        ram_addr    = lat_addr;
        ram_wr_data = lat_words[0];
      end
      ST_WRITE_BURST: ram_wr_data = lat_words[cnt[OFF_W-1:0]];
      ST_DONE:        req_done[gnt_idx] = 1'b1;
      default: ;
    endcase
  end

  // Read words land in the write-line buffer (unused for reads) so rd_line only changes when a read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      gnt_idx    <= 1'b0;
      lat_cmd    <= CMD_READ;
      lat_addr   <= '0;
      lat_words  <= '0;
      cnt        <= '0;
      rd_q       <= '0;
    end else begin
      if (grant_fire) begin
        last_grant <= grant_sel;
        gnt_idx    <= grant_sel;
        lat_cmd    <= sel_cmd;
        lat_addr   <= {sel_addr[AW-1:OFF_W], {OFF_W{1'b0}}};
        lat_words  <= sel_line;
      end
      if (state == ST_ISSUE) begin
        cnt <= (lat_cmd == CMD_WRITE) ? CNT_W'(1) : '0;
      end else if (state == ST_WRITE_BURST) begin
        cnt <= cnt + 1'b1;
      end else if (rd_fire) begin
        lat_words[cnt[OFF_W-1:0]] <= ram_rd_data;
        cnt                       <= cnt + 1'b1;
      end
      if ((state == ST_WAIT_RAM) && !ram_busy && (lat_cmd == CMD_READ)) begin
        rd_q <= lat_words;
      end
    end
  end

  assign rd_line       = rd_q;
  assign ram_data_mask = '0;

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Bench for burst_ram_arbiter with a burst RAM emulator (init 10, read delay 6) and a line-level memory model.
// Expectations for tie-breaking follow BURST_ARB_FIXED_PRIORITY_EN when it is defined for the build.
module tb_burst_ram_arbiter;
  import burst_ram_arbiter_pkg::*;

  localparam int AW = 4;
  localparam int DW = 64;
  localparam int BDC = 4;
  localparam int LW = DW * BDC;
  localparam int CALIB_CYCLES = 10;
  localparam int RD_DELAY = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req_en, req_cmd, req_done;
  logic [2*AW-1:0] req_addr;
  logic [2*LW-1:0] req_wr_line;
  logic [LW-1:0] rd_line;
  logic ram_cmd, ram_cmd_en, ram_rd_data_valid, ram_init_calib, ram_busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data, ram_rd_data;
  logic [DW/8-1:0] ram_data_mask;

  always #5 clk = ~clk;

  burst_ram_arbiter #(.AddressBitWidth(AW), .DataBitWidth(DW), .BurstDataCount(BDC)) dut (
    .clk(clk), .rst_n(rst_n), .req_en(req_en), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_wr_line(req_wr_line), .req_done(req_done), .rd_line(rd_line), .ram_cmd(ram_cmd),
    .ram_cmd_en(ram_cmd_en), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
    .ram_data_mask(ram_data_mask), .ram_rd_data(ram_rd_data), .ram_rd_data_valid(ram_rd_data_valid),
    .ram_init_calib(ram_init_calib), .ram_busy(ram_busy)
  );

  function automatic logic [DW-1:0] scr(input int a);
    return 64'h5A5A_0000_0000_0000 | (64'(a) * 64'h0000_0001_0001_0001);
  endfunction

  // Burst RAM emulator: storage is scrambled per address so unwritten words read back a known pattern.
  bit [DW-1:0] mem_x [16];
  int calib_cnt, busy_cnt, rd_wait, rd_left, wr_left;
  logic [AW-1:0] rd_ptr, wr_ptr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calib_cnt <= 0; ram_init_calib <= 1'b0; ram_busy <= 1'b0; busy_cnt <= 0;
      rd_wait <= 0; rd_left <= 0; wr_left <= 0; rd_ptr <= '0; wr_ptr <= '0;
      ram_rd_data <= '0; ram_rd_data_valid <= 1'b0;
    end else begin
      if (!ram_init_calib) begin
        calib_cnt <= calib_cnt + 1;
        if (calib_cnt >= CALIB_CYCLES - 1) ram_init_calib <= 1'b1;
      end
      ram_rd_data_valid <= 1'b0;
      if (ram_cmd_en) begin
        ram_busy <= 1'b1;
        if (ram_cmd == CMD_WRITE) begin
          mem_x[ram_addr] <= ram_wr_data ^ scr(int'(ram_addr));
          wr_ptr <= ram_addr + 4'd1; wr_left <= BDC - 1; busy_cnt <= BDC + 1;
        end else begin
          rd_ptr <= ram_addr; rd_wait <= RD_DELAY; rd_left <= BDC; busy_cnt <= RD_DELAY + BDC;
        end
      end else begin
        if (busy_cnt > 0) begin
          busy_cnt <= busy_cnt - 1;
          ram_busy <= (busy_cnt > 1);
        end
        if (wr_left > 0) begin
          mem_x[wr_ptr] <= ram_wr_data ^ scr(int'(wr_ptr));
          wr_ptr <= wr_ptr + 4'd1; wr_left <= wr_left - 1;
        end
        if (rd_left > 0) begin
          if (rd_wait > 1) rd_wait <= rd_wait - 1;
          else begin
            ram_rd_data_valid <= 1'b1;
            ram_rd_data <= mem_x[rd_ptr] ^ scr(int'(rd_ptr));
            rd_ptr <= rd_ptr + 4'd1; rd_left <= rd_left - 1;
          end
        end
      end
    end
  end

  int checks = 0, failures = 0;
  bit [DW-1:0] ref_mem [16];
  logic [LW-1:0] last_rd;
  bit pend [2];
  bit auto_rq [2];
  int rearm [2];
  int done_cnt [2];
  int max_gap;
  bit reads_only;
  logic rq_cmd [2];
  logic [AW-1:0] rq_addr [2];
  logic [LW-1:0] rq_line [2];
  int grant_log [$];
  logic [AW-1:0] iss_addr_q [$];
  logic iss_cmd_q [$];
  logic [AW-1:0] last_iss_addr;
  int issue_cnt = 0, done_total = 0, cmd_uncal = 0, dbl_done = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] ref_line(input int base);
    logic [LW-1:0] line;
    for (int w = 0; w < BDC; w++) line[w*DW +: DW] = ref_mem[base + w];
    return line;
  endfunction

  task automatic issue_req(input int i, input logic cmd, input logic [AW-1:0] a, input logic [LW-1:0] line);
    rq_cmd[i] = cmd; rq_addr[i] = a; rq_line[i] = line; pend[i] = 1'b1;
    req_cmd[i] = cmd;
    req_addr[i*AW +: AW] = a;
    req_wr_line[i*LW +: LW] = line;
    req_en[i] = 1'b1;
  endtask

  task automatic rand_req(input int i);
    logic [LW-1:0] line;
    logic cmd;
    for (int k = 0; k < LW/32; k++) line[k*32 +: 32] = $urandom();
    cmd = reads_only ? CMD_READ : ($urandom_range(0, 1) == 1);
    issue_req(i, cmd, AW'($urandom_range(0, 15)), line);
  endtask

  task automatic handle_done(input int i);
    int base;
    logic [LW-1:0] exp_line;
    done_total++; done_cnt[i]++; grant_log.push_back(i);
    chk("done_pending", pend[i], 1);
    base = int'(rq_addr[i]) / BDC * BDC;
    chk("issue_before_done", iss_addr_q.size() > 0, 1);
    if (iss_addr_q.size() > 0) begin
      chk("issue_addr", iss_addr_q.pop_front(), base);
      chk("issue_cmd", iss_cmd_q.pop_front(), rq_cmd[i]);
    end
    if (rq_cmd[i] == CMD_READ) begin
      exp_line = ref_line(base);
      chk("rd_line", rd_line, exp_line);
      last_rd = exp_line;
    end else begin
      for (int w = 0; w < BDC; w++) ref_mem[base + w] = rq_line[i][w*DW +: DW];
      chk("rd_line_hold", rd_line, last_rd);
    end
    req_en[i] = 1'b0; pend[i] = 1'b0;
    if (auto_rq[i]) rearm[i] = (max_gap == 0) ? 0 : $urandom_range(0, max_gap);
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rearm[i] == 0) begin rearm[i] = -1; rand_req(i); end
      else if (rearm[i] > 0) rearm[i]--;
    end
    if (ram_cmd_en) begin
      issue_cnt++;
      if (!ram_init_calib) cmd_uncal++;
      iss_addr_q.push_back(ram_addr); iss_cmd_q.push_back(ram_cmd);
      last_iss_addr = ram_addr;
    end
    if (req_done == 2'b11) dbl_done++;
    for (int i = 0; i < 2; i++) if (req_done[i]) handle_done(i);
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    int n = 0;
    while ((pend[0] || pend[1]) && n < budget) begin tick(); n++; end
    chk({tag, "_timeout"}, n >= budget, 0);
  endtask

  task automatic run_dones(input int target, input int budget, input string tag);
    int n = 0;
    int start = done_total;
    while ((done_total - start) < target && n < budget) begin tick(); n++; end
    chk({tag, "_timeout"}, n >= budget, 0);
    auto_rq[0] = 0; auto_rq[1] = 0; rearm[0] = -1; rearm[1] = -1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk(tag, {req_done, rd_line, ram_cmd, ram_cmd_en, ram_addr, ram_wr_data, ram_data_mask}, 0);
  endtask

  initial begin
    int s, n, alt_err, r1_cnt, d0, prev1;
    logic [LW-1:0] line4321;
    req_en = '0; req_cmd = '0; req_addr = '0; req_wr_line = '0; rst_n = 1'b0;
    pend[0] = 0; pend[1] = 0; auto_rq[0] = 0; auto_rq[1] = 0; rearm[0] = -1; rearm[1] = -1;
    done_cnt[0] = 0; done_cnt[1] = 0; max_gap = 0; reads_only = 1'b1; last_rd = '0;
    for (int a = 0; a < 16; a++) ref_mem[a] = scr(a);
    line4321 = {64'd4, 64'd3, 64'd2, 64'd1};

    repeat (3) @(negedge clk);
    chk_outputs_zero("reset_outputs");
    rst_n = 1'b1;

    // Request during calibration must wait for init_calib.
    tick(); tick();
    issue_req(0, CMD_READ, 4'd9, '0);
    run_until_idle(200, "calib_read");
    chk("calib_no_early_cmd", cmd_uncal, 0);
    chk("calib_issue_count", issue_cnt, 1);
    chk("calib_done_count", done_cnt[0], 1);

    issue_req(0, CMD_WRITE, 4'd4, line4321);
    run_until_idle(200, "write4");
    issue_req(1, CMD_READ, 4'd4, '0);
    run_until_idle(200, "read4");
    chk("wr_rd_line", rd_line, line4321);

    issue_req(0, CMD_READ, 4'd7, '0);
    run_until_idle(200, "read7");
    chk("align_addr", last_iss_addr, 4);
    chk("align_line", rd_line, line4321);

    // Both requesters reading back to back.
    s = grant_log.size();
    reads_only = 1'b1; max_gap = 0; auto_rq[0] = 1; auto_rq[1] = 1;
    rand_req(0); rand_req(1);
    run_dones(8, 600, "rr");
    run_until_idle(400, "rr_drain");
    alt_err = 0; r1_cnt = 0;
    for (int k = s; k < s + 8 && k < grant_log.size(); k++) begin
      if (grant_log[k] == 1) r1_cnt++;
      if (k > s && grant_log[k] == grant_log[k-1]) alt_err++;
    end
`ifdef BURST_ARB_FIXED_PRIORITY_EN
    chk("fixed_r1_grants", r1_cnt, 0);
`else
    chk("rr_alternate", alt_err, 0);
    chk("rr_r1_within_2", (grant_log.size() > s + 1) && (grant_log[s] == 1 || grant_log[s+1] == 1), 1);
`endif

    // Reset in the middle of a read burst.
    issue_req(1, CMD_READ, 4'd8, '0);
    n = 0;
    while (!ram_rd_data_valid && n < 100) begin tick(); n++; end
    chk("mb_collect_reached", ram_rd_data_valid, 1);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("mid_reset_outputs");
    d0 = done_total;
    repeat (3) tick();
    chk("mid_reset_no_done", done_total - d0, 0);
    iss_addr_q.delete(); iss_cmd_q.delete(); last_rd = '0;
    s = grant_log.size(); prev1 = done_cnt[1];
    issue_req(0, CMD_READ, 4'd1, '0);
    rst_n = 1'b1;
    run_until_idle(400, "mid_reset_recover");
    chk("mid_reset_tie_r0", (grant_log.size() > s) ? grant_log[s] : -1, 0);
    chk("mid_reset_served_r1", done_cnt[1] - prev1, 1);

    reads_only = 1'b0; max_gap = 3; auto_rq[0] = 1; auto_rq[1] = 1;
    rand_req(0); rand_req(1);
    run_dones(40, 4000, "rand");
    run_until_idle(400, "rand_drain");

    chk("issue_done_balance", iss_addr_q.size(), 0);
    chk("double_done", dbl_done, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
